crc_lut_slice4: RTL and testbench

Slicing-by-4 CRC-32 engine that consumes four external byte-indexed lookup tables (one table module per slice, combinational read, 32-bit `addr` / 32-bit `rdata`). It accepts a framed 32-bit word stream over a valid/ready handshake, drives the four table addresses from the running CRC XOR data, and XOR-combines the returned words into the next CRC. Partial final words are finished byte-serially through slice 0. It sits directly upstream of the tables and produces the per-frame CRC result for the framer.

---
 rtl/crc_lut_slice4.sv | 156 +++++++++++++++
 tb/tb_crc_lut_slice4.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_lut_slice4.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : crc_lut_slice4
// Brief    : Slicing-by-4 CRC-32 (poly 0x04C11DB7, MSB-first) engine driving
//            four external combinational byte lookup tables. Full words are
//            folded in one cycle; partial final words finish byte-serially
//            through table 0.
// Options  : CRC_LUT_SLICE4_XOROUT_EN - when defined, crc_out is inverted
//            (CRC-32/BZIP2); otherwise crc_out is the raw register
//            (CRC-32/MPEG-2).
// Revision : 1.0 - initial release
// ============================================================================
module crc_lut_slice4 #(
    parameter logic [31:0] INIT = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    input  logic [1:0]  s_nbytes,
    output logic [31:0] tab_addr0,
    output logic [31:0] tab_addr1,
    output logic [31:0] tab_addr2,
    output logic [31:0] tab_addr3,
    input  logic [31:0] tab_rdata0,
    input  logic [31:0] tab_rdata1,
    input  logic [31:0] tab_rdata2,
    input  logic [31:0] tab_rdata3,
    output logic [31:0] crc_out,
    output logic        crc_valid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_TAIL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

`ifdef CRC_LUT_SLICE4_XOROUT_EN
    localparam logic [31:0] c_xorout = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] c_xorout = 32'h0000_0000;
`endif

    logic [1:0]  r_state;
    logic [31:0] r_crc;
    logic [31:0] r_shift;
    logic [1:0]  r_cnt;
    logic [31:0] r_crc_out;
    logic        r_crc_valid;

    logic [1:0]  w_next_state;
    logic [31:0] w_crc_next;
    logic [31:0] w_shift_next;
    logic [1:0]  w_cnt_next;
    logic        w_load_out;
    logic [31:0] w_result;
    logic [31:0] w_c;
    logic [31:0] w_x;
    logic [31:0] w_full;
    logic [31:0] w_tail;

    // A new frame always starts from INIT, so IDLE ignores whatever the
    // register still holds from the previous frame.
    assign w_c    = (r_state == S_IDLE) ? INIT : r_crc;
    assign w_x    = w_c ^ s_data;
    assign w_full = tab_rdata3 ^ tab_rdata2 ^ tab_rdata1 ^ tab_rdata0;
    assign w_tail = {r_crc[23:0], 8'h00} ^ tab_rdata0;

    assign crc_out   = r_crc_out;
    assign crc_valid = r_crc_valid;

    // Next-state, table addressing and handshake decode
    always_comb begin
        w_next_state = r_state;
        w_crc_next   = r_crc;
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        w_load_out   = 1'b0;
        w_result     = w_full;
        s_ready      = 1'b0;
        tab_addr0    = 32'h0;
        tab_addr1    = 32'h0;
        tab_addr2    = 32'h0;
        tab_addr3    = 32'h0;
        case (r_state)
            S_IDLE, S_RUN: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    tab_addr3 = {24'h0, w_x[31:24]};
                    tab_addr2 = {24'h0, w_x[23:16]};
                    tab_addr1 = {24'h0, w_x[15:8]};
                    tab_addr0 = {24'h0, w_x[7:0]};
                    if (!s_last) begin
                        w_crc_next   = w_full;
                        w_next_state = S_RUN;
                    end else if (s_nbytes == 2'd3) begin
                        w_crc_next   = w_full;
                        w_load_out   = 1'b1;
                        w_result     = w_full;
                        w_next_state = S_DONE;
                    end else begin
                        // Partial word: keep the running CRC and let TAIL
                        // fold the valid bytes in one at a time.
                        w_crc_next   = w_c;
                        w_shift_next = s_data;
                        w_cnt_next   = s_nbytes + 2'd1;
                        w_next_state = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                tab_addr0    = {24'h0, r_crc[31:24] ^ r_shift[31:24]};
                w_crc_next   = w_tail;
                w_shift_next = {r_shift[23:0], 8'h00};
                w_cnt_next   = r_cnt - 2'd1;
                if (r_cnt == 2'd1) begin
                    w_load_out   = 1'b1;
                    w_result     = w_tail;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, CRC datapath and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_crc       <= INIT;
            r_shift     <= 32'h0;
            r_cnt       <= 2'd0;
            r_crc_out   <= 32'h0;
            r_crc_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_crc       <= w_crc_next;
            r_shift     <= w_shift_next;
            r_cnt       <= w_cnt_next;
            r_crc_valid <= w_load_out;
            if (w_load_out) begin
                r_crc_out <= w_result ^ c_xorout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_lut_slice4.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_crc_lut_slice4
// Brief    : Bench for crc_lut_slice4 with behavioural tables and a
//            byte-level bitwise CRC reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_lut_slice4;

    localparam logic [31:0] c_init = 32'hFFFF_FFFF;
    localparam logic [31:0] c_poly = 32'h04C11DB7;
`ifdef CRC_LUT_SLICE4_XOROUT_EN
    localparam logic [31:0] c_xorout = 32'hFFFF_FFFF;
    localparam logic [31:0] c_check  = 32'hFC891918;
`else
    localparam logic [31:0] c_xorout = 32'h0000_0000;
    localparam logic [31:0] c_check  = 32'h0376E6E7;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [1:0]  s_nbytes;
    logic [31:0] tab_addr0, tab_addr1, tab_addr2, tab_addr3;
    logic [31:0] tab_rdata0, tab_rdata1, tab_rdata2, tab_rdata3;
    logic [31:0] crc_out;
    logic        crc_valid;

    crc_lut_slice4 #(.INIT(c_init)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_last     (s_last),
        .s_nbytes   (s_nbytes),
        .tab_addr0  (tab_addr0),
        .tab_addr1  (tab_addr1),
        .tab_addr2  (tab_addr2),
        .tab_addr3  (tab_addr3),
        .tab_rdata0 (tab_rdata0),
        .tab_rdata1 (tab_rdata1),
        .tab_rdata2 (tab_rdata2),
        .tab_rdata3 (tab_rdata3),
        .crc_out    (crc_out),
        .crc_valid  (crc_valid)
    );

    // Behavioural lookup tables
    logic [31:0] t0 [256];
    logic [31:0] t1 [256];
    logic [31:0] t2 [256];
    logic [31:0] t3 [256];
    assign tab_rdata0 = t0[tab_addr0[7:0]];
    assign tab_rdata1 = t1[tab_addr1[7:0]];
    assign tab_rdata2 = t2[tab_addr2[7:0]];
    assign tab_rdata3 = t3[tab_addr3[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bitwise MSB-first CRC update by one byte
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {b, 24'h0};
        for (int i = 0; i < 8; i++) c = c[31] ? ((c << 1) ^ c_poly) : (c << 1);
        return c;
    endfunction

    // Reference model state: bytes of the current frame and the expected
    // number of cycles the engine remains busy after a final beat.
    logic [7:0]  frame_q [$];
    logic [31:0] cap_q [$];
    int          busy;
    int          tail_start;
    int          tail_n;
    logic [31:0] exp_out;
    logic [31:0] pending;
    bit          model_ok = 1'b0;

    function automatic logic [31:0] crc_of(input int len);
        logic [31:0] c;
        c = c_init;
        for (int i = 0; i < len; i++) c = crc_step(c, frame_q[i]);
        return c;
    endfunction

    // Model advance on each rising edge
    always @(posedge clk) begin : model
        bit ready_now;
        int nb;
        if (rst) begin
            busy     = 0;
            exp_out  = 32'h0;
            frame_q.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            ready_now = (busy == 0);
            if (busy > 0) begin
                busy--;
                if (busy == 0) frame_q.delete();
            end
            if (ready_now && s_valid) begin
                nb = s_last ? int'(s_nbytes) + 1 : 4;
                tail_start = frame_q.size();
                for (int i = 0; i < nb; i++) frame_q.push_back(s_data[31-8*i -: 8]);
                if (s_last) begin
                    pending = crc_of(frame_q.size()) ^ c_xorout;
                    tail_n  = nb;
                    busy    = (nb == 4) ? 1 : nb + 1;
                end
            end
            if (busy == 1) exp_out = pending;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin : compare
        logic [31:0] ec, ex, e0, e1, e2, e3;
        int idx;
        if (model_ok) begin
            chk("s_ready", 32'(s_ready), 32'(busy == 0));
            chk("crc_valid", 32'(crc_valid), 32'(busy == 1));
            chk("crc_out", crc_out, exp_out);
            e0 = 32'h0; e1 = 32'h0; e2 = 32'h0; e3 = 32'h0;
            if (busy == 0 && s_valid) begin
                ec = crc_of(frame_q.size());
                ex = ec ^ s_data;
                e3 = {24'h0, ex[31:24]};
                e2 = {24'h0, ex[23:16]};
                e1 = {24'h0, ex[15:8]};
                e0 = {24'h0, ex[7:0]};
            end else if (busy > 1) begin
                idx = tail_start + (tail_n + 1 - busy);
                ec  = crc_of(idx);
                e0  = {24'h0, ec[31:24] ^ frame_q[idx]};
            end
            chk("tab_addr0", tab_addr0, e0);
            chk("tab_addr1", tab_addr1, e1);
            chk("tab_addr2", tab_addr2, e2);
            chk("tab_addr3", tab_addr3, e3);
            if (crc_valid) cap_q.push_back(crc_out);
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic last, input logic [1:0] nb, input bit hold);
        int g;
        g = 0;
        s_data = d; s_valid = 1'b1; s_last = last; s_nbytes = nb;
        @(negedge clk);
        while (!s_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) begin
            checks++; failures++;
            $display("FAIL send_timeout: s_ready got 0 required 1");
        end
        @(posedge clk); #1;
        if (!hold) begin
            s_valid = 1'b0; s_last = 1'b0;
        end
    endtask

    // Wait for the result pulse; lat counts cycles after the last accept
    task automatic finish_frame(output logic [31:0] v, output int lat, output int low);
        bit got;
        got = 1'b0; v = 32'h0; lat = -1; low = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!s_ready) low++;
            if (crc_valid && !got) begin
                got = 1'b1; v = crc_out; lat = i;
            end
            if (s_ready) break;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL result_timeout: crc_valid got 0 required 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_check_frame(input bit gaps, input bit hold);
        send_beat(32'h31323334, 1'b0, 2'd0, hold);
        if (gaps) begin repeat (3) @(posedge clk); #1; end
        send_beat(32'h35363738, 1'b0, 2'd0, hold);
        if (gaps) begin repeat (3) @(posedge clk); #1; end
        send_beat(32'h39000000, 1'b1, 2'd0, 1'b0);
    endtask

    logic [31:0] v, crc_a, exp_b, lit;
    int lat, low, n0;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst = 1'b1; s_valid = 1'b0; s_data = 32'h0; s_last = 1'b0; s_nbytes = 2'd0;
        for (int b = 0; b < 256; b++) begin
            t0[b] = crc_step(32'h0, 8'(b));
            t1[b] = crc_step(t0[b], 8'h00);
            t2[b] = crc_step(t1[b], 8'h00);
            t3[b] = crc_step(t2[b], 8'h00);
        end
        // Pin the reference itself to hand-known values
        chk("model_t0_1", t0[1], 32'h04C11DB7);
        chk("model_t0_2", t0[2], 32'h09823B6E);
        lit = c_init;
        for (int i = 0; i < 9; i++) lit = crc_step(lit, 8'h31 + 8'(i));
        chk("model_check", lit, 32'h0376E6E7);

        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(s_ready), 32'd1);
        chk("reset_valid", 32'(crc_valid), 32'd0);
        chk("reset_out", crc_out, 32'h0);
        @(posedge clk); #1;

        // "123456789", no gaps
        send_check_frame(1'b0, 1'b0);
        finish_frame(v, lat, low);
        chk("a_crc", v, c_check);
        chk("a_latency", 32'(lat), 32'd2);
        chk("a_ready_low", 32'(low), 32'd2);
        crc_a = v;

        // "12345678", full final word
        send_beat(32'h31323334, 1'b0, 2'd0, 1'b0);
        send_beat(32'h35363738, 1'b1, 2'd3, 1'b0);
        finish_frame(v, lat, low);
        exp_b = c_init;
        for (int i = 0; i < 8; i++) exp_b = crc_step(exp_b, 8'h31 + 8'(i));
        chk("b_crc", v, exp_b ^ c_xorout);
        chk("b_latency", 32'(lat), 32'd1);
        chk("b_ready_low", 32'(low), 32'd1);

        // Same as the first frame with 3-cycle valid gaps
        send_check_frame(1'b1, 1'b0);
        finish_frame(v, lat, low);
        chk("gap_crc", v, crc_a);
        chk("gap_latency", 32'(lat), 32'd2);

        // Back-to-back identical frames, valid held high
        n0 = cap_q.size();
        send_check_frame(1'b0, 1'b1);
        send_check_frame(1'b0, 1'b1);
        finish_frame(v, lat, low);
        chk("b2b_count", 32'(cap_q.size() - n0), 32'd2);
        if (cap_q.size() >= n0 + 2) begin
            chk("b2b_first", cap_q[n0], c_check);
            chk("b2b_second", cap_q[n0+1], c_check);
        end

        // Other tail lengths and single-beat frames
        send_beat(32'hA5B6C700, 1'b1, 2'd1, 1'b0);
        finish_frame(v, lat, low);
        chk("tail2_latency", 32'(lat), 32'd3);
        chk("tail2_ready_low", 32'(low), 32'd3);
        send_beat(32'hDEADBEEF, 1'b1, 2'd3, 1'b0);
        finish_frame(v, lat, low);
        chk("single_full_latency", 32'(lat), 32'd1);
        send_beat(32'h01020304, 1'b0, 2'd0, 1'b0);
        send_beat(32'hFFEEDDCC, 1'b0, 2'd0, 1'b0);
        send_beat(32'h11223300, 1'b1, 2'd2, 1'b0);
        finish_frame(v, lat, low);
        chk("tail3_latency", 32'(lat), 32'd4);
        chk("tail3_ready_low", 32'(low), 32'd4);

        // Reset while in TAIL
        send_beat(32'h31323334, 1'b0, 2'd0, 1'b0);
        send_beat(32'h35363738, 1'b0, 2'd0, 1'b0);
        send_beat(32'h39000000, 1'b1, 2'd2, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("tail_rst_valid", 32'(crc_valid), 32'd0);
        chk("tail_rst_out", crc_out, 32'h0);
        chk("tail_rst_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;

        send_check_frame(1'b0, 1'b0);
        finish_frame(v, lat, low);
        chk("post_rst_crc", v, c_check);
        chk("post_rst_latency", 32'(lat), 32'd2);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
